config_mem_rw: RTL and testbench

//  Per-core neuron configuration memory with run-time reload. It holds region A
//  (STDP params), region B (neuron params and AER) and region C (per-synapse

---
 rtl/config_mem_rw.sv | 216 +++++++++++++++++++++
 tb/tb_config_mem_rw.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_mem_rw.sv
// Per-core neuron configuration memory: three registered read ports over regions A/B/C
// plus a valid/ready word-stream loader (header, payload words, commit) for run-time reprogramming.
module config_mem_rw #(
  parameter int unsigned NUM_NURNS          = 256,
  parameter int unsigned NUM_AXONS          = 256,
  parameter int unsigned DSIZE              = 16,
  parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
  parameter int unsigned AXON_CNT_BIT_WIDTH = 8,
  parameter int unsigned STDP_WIN_BIT_WIDTH = 8,
  parameter int unsigned AER_BIT_WIDTH      = 32,
  parameter int unsigned CFG_WORD_W         = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_A_i,
  input  logic                                         rdEn_Config_A_i,
  output logic [STDP_WIN_BIT_WIDTH-1:0]                LTP_Win_o,
  output logic [STDP_WIN_BIT_WIDTH-1:0]                LTD_Win_o,
  output logic [DSIZE-1:0]                             LTP_LrnRt_o,
  output logic [DSIZE-1:0]                             LTD_LrnRt_o,
  output logic                                         biasLrnMode_o,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_B_i,
  input  logic                                         rdEn_Config_B_i,
  output logic                                         NurnType_o,
  output logic                                         RandTh_o,
  output logic [DSIZE-1:0]                             Th_Mask_o,
  output logic [DSIZE-1:0]                             RstPot_o,
  output logic [AER_BIT_WIDTH-1:0]                     SpikeAER_o,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_i,
  input  logic                                         rdEn_Config_C_i,
  output logic                                         axonLrnMode_o,
  input  logic [CFG_WORD_W-1:0]                        cfg_data_i,
  input  logic                                         cfg_valid_i,
  output logic                                         cfg_ready_o,
  output logic                                         cfg_done_o,
  output logic                                         cfg_err_o
);

  localparam int unsigned AW       = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
  localparam int unsigned WA       = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
  localparam int unsigned WB       = 2 + 2*DSIZE + AER_BIT_WIDTH;
  localparam int unsigned NA       = (WA + CFG_WORD_W - 1) / CFG_WORD_W;
  localparam int unsigned NB       = (WB + CFG_WORD_W - 1) / CFG_WORD_W;
  localparam int unsigned NC       = 1;
  localparam int unsigned WMAX     = (WA > WB) ? WA : WB;
  localparam int unsigned NMAX     = (NA > NB) ? NA : NB;
  localparam int unsigned WIDE     = NMAX * CFG_WORD_W;
  localparam int unsigned CNT_W    = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int unsigned DEPTH_AB = NUM_NURNS;
  localparam int unsigned DEPTH_C  = NUM_NURNS * NUM_AXONS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [1:0] RGN_A   = 2'd0;
  localparam logic [1:0] RGN_B   = 2'd1;
  localparam logic [1:0] RGN_C   = 2'd2;
  localparam logic [1:0] RGN_BAD = 2'd3;

  logic [WA-1:0] mem_a [DEPTH_AB];
  logic [WB-1:0] mem_b [DEPTH_AB];
  logic          mem_c [DEPTH_C];

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       region_q, region_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WMAX-1:0]  ent_q, ent_d;
  logic [WA-1:0]    rd_a_q, rd_a_d;
  logic [WB-1:0]    rd_b_q, rd_b_d;
  logic             rd_c_q, rd_c_d;

  logic             accept;
  logic             addr_ok;
  logic             tgt_rden;
  logic [CNT_W-1:0] last_cnt;
  logic             wr_a, wr_b, wr_c;

  assign accept = cfg_valid_i & ready_q;

  always_comb begin
    addr_ok  = 1'b0;
    tgt_rden = 1'b0;
    last_cnt = '0;
    case (region_q)
      RGN_A: begin
        addr_ok  = 32'(addr_q[NURN_CNT_BIT_WIDTH-1:0]) < DEPTH_AB;
        tgt_rden = rdEn_Config_A_i;
        last_cnt = CNT_W'(NA - 1);
      end
      RGN_B: begin
        addr_ok  = 32'(addr_q[NURN_CNT_BIT_WIDTH-1:0]) < DEPTH_AB;
        tgt_rden = rdEn_Config_B_i;
        last_cnt = CNT_W'(NB - 1);
      end
      RGN_C: begin
        addr_ok  = 32'(addr_q) < DEPTH_C;
        tgt_rden = rdEn_Config_C_i;
        last_cnt = CNT_W'(NC - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = err_q;
    region_d = region_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ent_d    = ent_q;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    wr_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (cfg_data_i[CFG_WORD_W-1 -: 2] == RGN_BAD) begin
            err_d = 1'b1;
          end else begin
            region_d = cfg_data_i[CFG_WORD_W-1 -: 2];
            addr_d   = cfg_data_i[AW-1:0];
            cnt_d    = '0;
            ent_d    = '0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ready_d = 1'b1;
        if (accept) begin
          // Entry is cleared on header, so OR-ing each shifted word places it; bits >= WMAX fall off the cast.
          ent_d = ent_q | WMAX'(WIDE'(cfg_data_i) << (cnt_q * CFG_WORD_W));
          if (cnt_q == last_cnt) begin
            ready_d = 1'b0;
            state_d = S_COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMMIT: begin
        ready_d = 1'b0;
        if (!addr_ok) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else if (!tgt_rden) begin
          wr_a    = (region_q == RGN_A);
          wr_b    = (region_q == RGN_B);
          wr_c    = (region_q == RGN_C);
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_a_d = rdEn_Config_A_i ? mem_a[Addr_Config_A_i] : rd_a_q;
    rd_b_d = rdEn_Config_B_i ? mem_b[Addr_Config_B_i] : rd_b_q;
    rd_c_d = rdEn_Config_C_i ? mem_c[Addr_Config_C_i] : rd_c_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      region_q <= RGN_A;
      addr_q   <= '0;
      cnt_q    <= '0;
      ent_q    <= '0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      rd_c_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      ent_q    <= ent_d;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      rd_c_q   <= rd_c_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_n_i.
  always_ff @(posedge clk_i) begin
    if (wr_a) mem_a[addr_q[NURN_CNT_BIT_WIDTH-1:0]] <= ent_q[WA-1:0];
    if (wr_b) mem_b[addr_q[NURN_CNT_BIT_WIDTH-1:0]] <= ent_q[WB-1:0];
    if (wr_c) mem_c[addr_q] <= ent_q[0];
  end

  assign {LTP_Win_o, LTD_Win_o, LTP_LrnRt_o, LTD_LrnRt_o, biasLrnMode_o} = rd_a_q;
  assign {NurnType_o, RandTh_o, Th_Mask_o, RstPot_o, SpikeAER_o}         = rd_b_q;
  assign axonLrnMode_o = rd_c_q;
  assign cfg_ready_o   = ready_q;
  assign cfg_done_o    = done_q;
  assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_config_mem_rw.sv
// Scoreboard bench for config_mem_rw: loads entries through the config stream and
// checks registered read data against a bench-side memory model.
module tb_config_mem_rw;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [7:0]  Addr_Config_A_i, Addr_Config_B_i;
  logic [15:0] Addr_Config_C_i;
  logic        rdEn_Config_A_i, rdEn_Config_B_i, rdEn_Config_C_i;
  logic [7:0]  LTP_Win_o, LTD_Win_o;
  logic [15:0] LTP_LrnRt_o, LTD_LrnRt_o, Th_Mask_o, RstPot_o;
  logic        biasLrnMode_o, NurnType_o, RandTh_o, axonLrnMode_o;
  logic [31:0] SpikeAER_o;
  logic [31:0] cfg_data_i;
  logic        cfg_valid_i, cfg_ready_o, cfg_done_o, cfg_err_o;

  always #5 clk_i = ~clk_i;

  config_mem_rw dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .Addr_Config_A_i(Addr_Config_A_i), .rdEn_Config_A_i(rdEn_Config_A_i),
    .LTP_Win_o(LTP_Win_o), .LTD_Win_o(LTD_Win_o),
    .LTP_LrnRt_o(LTP_LrnRt_o), .LTD_LrnRt_o(LTD_LrnRt_o), .biasLrnMode_o(biasLrnMode_o),
    .Addr_Config_B_i(Addr_Config_B_i), .rdEn_Config_B_i(rdEn_Config_B_i),
    .NurnType_o(NurnType_o), .RandTh_o(RandTh_o), .Th_Mask_o(Th_Mask_o),
    .RstPot_o(RstPot_o), .SpikeAER_o(SpikeAER_o),
    .Addr_Config_C_i(Addr_Config_C_i), .rdEn_Config_C_i(rdEn_Config_C_i),
    .axonLrnMode_o(axonLrnMode_o),
    .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [48:0] ma [256];
  logic [65:0] mb [256];
  logic        mc [65536];

  typedef struct {
    string       tag;
    int          sel;
    logic [65:0] exp;
  } sb_t;
  sb_t sbq[$];

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] observe(input int sel);
    case (sel)
      0: return 66'({LTP_Win_o, LTD_Win_o, LTP_LrnRt_o, LTD_LrnRt_o, biasLrnMode_o});
      1: return {NurnType_o, RandTh_o, Th_Mask_o, RstPot_o, SpikeAER_o};
      2: return 66'(axonLrnMode_o);
      3: return 66'(LTP_Win_o);
      4: return 66'(LTD_Win_o);
      5: return 66'(biasLrnMode_o);
      6: return 66'(SpikeAER_o);
      default: return '0;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [65:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      sb_t e;
      e = sbq.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_port(input int port, input logic [15:0] addr, input string tag);
    case (port)
      0: begin rdEn_Config_A_i = 1'b1; Addr_Config_A_i = addr[7:0]; expect_out(tag, 0, 66'(ma[addr[7:0]])); end
      1: begin rdEn_Config_B_i = 1'b1; Addr_Config_B_i = addr[7:0]; expect_out(tag, 1, mb[addr[7:0]]); end
      default: begin rdEn_Config_C_i = 1'b1; Addr_Config_C_i = addr; expect_out(tag, 2, 66'(mc[addr])); end
    endcase
    tick();
    rdEn_Config_A_i = 1'b0;
    rdEn_Config_B_i = 1'b0;
    rdEn_Config_C_i = 1'b0;
    drain();
  endtask

  task automatic send_word(input logic [31:0] d);
    int t;
    t = 0;
    cfg_data_i  = d;
    cfg_valid_i = 1'b1;
    while (!cfg_ready_o && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("ready_wait", 66'(cfg_ready_o), 66'(1));
    tick();
    cfg_valid_i = 1'b0;
    cfg_data_i  = $urandom();
  endtask

  task automatic load(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input int bubbles, input string tag);
    logic [31:0] w [3];
    logic [63:0] ab;
    logic [95:0] c3;
    logic [1:0]  rgn;
    logic [15:0] a;
    int          nw;
    int          t;
    w[0] = w0; w[1] = w1; w[2] = w2;
    rgn = hdr[31:30];
    a   = hdr[15:0];
    nw  = (rgn == 2'd0) ? 2 : (rgn == 2'd1) ? 3 : 1;
    send_word(hdr);
    for (int i = 0; i < nw; i++) begin
      repeat (bubbles) tick();
      send_word(w[i]);
    end
    check({tag, "_ready_drop"}, 66'(cfg_ready_o), 66'(0));
    t = 0;
    while (!cfg_done_o && t < 20) begin
      tick();
      t++;
    end
    check({tag, "_done"}, 66'(cfg_done_o), 66'(1));
    check({tag, "_ready_back"}, 66'(cfg_ready_o), 66'(1));
    tick();
    check({tag, "_done_once"}, 66'(cfg_done_o), 66'(0));
    ab = {w1, w0};
    c3 = {w2, w1, w0};
    case (rgn)
      2'd0:    ma[a[7:0]] = ab[48:0];
      2'd1:    mb[a[7:0]] = c3[65:0];
      default: mc[a] = w0[0];
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, observe(0), '0);
    check({tag, "_b"}, observe(1), '0);
    check({tag, "_c"}, observe(2), '0);
    check({tag, "_ready"}, 66'(cfg_ready_o), 66'(0));
    check({tag, "_done"}, 66'(cfg_done_o), 66'(0));
    check({tag, "_err"}, 66'(cfg_err_o), 66'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    Addr_Config_A_i = '0; Addr_Config_B_i = '0; Addr_Config_C_i = '0;
    rdEn_Config_A_i = 1'b0; rdEn_Config_B_i = 1'b0; rdEn_Config_C_i = 1'b0;
    cfg_data_i = '0; cfg_valid_i = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (3) tick();
    rst_n_i = 1'b1;
    check("ready_before_edge", 66'(cfg_ready_o), 66'(0));
    tick();
    check("ready_after_edge", 66'(cfg_ready_o), 66'(1));

    // 1: region A entry, field split
    load(32'h0000_0005, 32'h89AB_CDEF, 32'h0001_2345, 32'h0, 0, "t1");
    expect_out("t1_ltp_win", 3, 66'(ma[5][48:41]));
    expect_out("t1_ltd_win", 4, 66'(ma[5][40:33]));
    expect_out("t1_bias", 5, 66'(1));
    read_port(0, 16'd5, "t1_a_entry");
    Addr_Config_A_i = 8'd6;
    expect_out("t1_hold", 0, 66'(ma[5]));
    tick();
    drain();

    // 2: region B at top address, upper payload bits dropped
    load(32'h4000_00FF, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFE, 0, "t2");
    expect_out("t2_aer", 6, 66'(32'hDEAD_BEEF));
    read_port(1, 16'd255, "t2_b_entry");

    // 3: region C commit stalled by a same-region read
    load(32'h8000_0103, 32'h0, 32'h0, 32'h0, 0, "t3pre");
    rdEn_Config_C_i = 1'b1;
    Addr_Config_C_i = 16'h0103;
    send_word(32'h8000_0103);
    send_word(32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      expect_out("t3_old_data", 2, 66'(mc[16'h0103]));
      tick();
      check("t3_stall_ready", 66'(cfg_ready_o), 66'(0));
      check("t3_stall_done", 66'(cfg_done_o), 66'(0));
      drain();
    end
    rdEn_Config_C_i = 1'b0;
    tick();
    check("t3_done", 66'(cfg_done_o), 66'(1));
    check("t3_ready_back", 66'(cfg_ready_o), 66'(1));
    mc[16'h0103] = 1'b1;
    read_port(2, 16'h0103, "t3_new_data");

    // 4: illegal region header, then a normal load with sticky error
    send_word(32'hC000_0000);
    check("t4_err", 66'(cfg_err_o), 66'(1));
    check("t4_idle_ready", 66'(cfg_ready_o), 66'(1));
    load(32'h0000_0007, 32'h1111_2222, 32'h3333_4444, 32'h0, 0, "t4");
    check("t4_err_sticky", 66'(cfg_err_o), 66'(1));
    read_port(0, 16'd7, "t4_a_entry");

    // 5: reset in the middle of a load
    send_word(32'h0000_0005);
    send_word(32'hFFFF_FFFF);
    rst_n_i = 1'b0;
    #2;
    check_all_zero("t5_reset");
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();
    read_port(0, 16'd5, "t5_a_unchanged");
    load(32'h0000_0005, 32'hCAFE_F00D, 32'h0000_BEEF, 32'h0, 0, "t5");
    read_port(0, 16'd5, "t5_a_reload");

    // 6: bubbles between payload words, with a concurrent region-B read that must not stall
    rdEn_Config_B_i = 1'b1;
    Addr_Config_B_i = 8'd255;
    load(32'h0000_0009, 32'h5A5A_0F0F, 32'h0001_C3C3, 32'h0, 3, "t6_bubbles");
    rdEn_Config_B_i = 1'b0;
    load(32'h0000_000A, 32'h5A5A_0F0F, 32'h0001_C3C3, 32'h0, 0, "t6_plain");
    read_port(0, 16'd9, "t6_a_bubbles");
    read_port(0, 16'd10, "t6_a_plain");

    // top of region C
    load(32'h8000_FFFF, 32'h0000_0001, 32'h0, 32'h0, 1, "tc_top");
    read_port(2, 16'hFFFF, "tc_top_read");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
